// File: rtl/aes_if_pkg.sv
// Shared definitions for the Avalon-MM AES register interface:
// register indices, run-state encoding and control/status bit positions.
package aes_if_pkg;

  localparam logic [3:0] KEY0   = 4'd0;
  localparam logic [3:0] KEY1   = 4'd1;
  localparam logic [3:0] KEY2   = 4'd2;
  localparam logic [3:0] KEY3   = 4'd3;
  localparam logic [3:0] MSG0   = 4'd4;
  localparam logic [3:0] MSG1   = 4'd5;
  localparam logic [3:0] MSG2   = 4'd6;
  localparam logic [3:0] MSG3   = 4'd7;
  localparam logic [3:0] DEC0   = 4'd8;
  localparam logic [3:0] DEC1   = 4'd9;
  localparam logic [3:0] DEC2   = 4'd10;
  localparam logic [3:0] DEC3   = 4'd11;
  localparam logic [3:0] SCR0   = 4'd12;
  localparam logic [3:0] SCR1   = 4'd13;
  localparam logic [3:0] CTRL   = 4'd14;
  localparam logic [3:0] STATUS = 4'd15;

  localparam int unsigned START_BIT = 0;
  localparam int unsigned DONE_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } run_state_e;

endpackage

// File: rtl/avalon_aes_interface_be_reg32.sv
// be_reg32: 32-bit register with per-byte write enables and asynchronous
// active-high reset.
module be_reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (be[n]) q_d[8*n +: 8] = d[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/avalon_aes_interface.sv
// Avalon-MM register front end for an AES decrypt core (16 x 32-bit words).
// Optional feature: define AES_IRQ_EN to add the IRQ output (done interrupt).
module avalon_aes_interface
  import aes_if_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
`ifdef AES_IRQ_EN
  ,
  output logic         IRQ
`endif
);

  logic [31:0] r [16];
  run_state_e  state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_wr, ctrl_wr, start_cur, start_next, capture;
  logic [31:0] ctrl_wdata, status_word;

  assign bus_wr     = AVL_CS & AVL_WRITE;
  assign ctrl_wr    = bus_wr && (AVL_ADDR == CTRL) && AVL_BYTE_EN[0];
  assign start_cur  = r[CTRL][START_BIT];
  // The FSM looks at the value R14 is about to take so a START write is seen on its own edge.
  assign start_next = ctrl_wr ? AVL_WRITEDATA[START_BIT] : start_cur;

  for (genvar i = 0; i < 14; i++) begin : g_reg
    localparam logic [3:0] IDX      = 4'(i);
    localparam bit         LOCKABLE = (IDX <= MSG3);
    logic        we;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] q;

    if (IDX >= DEC0 && IDX <= DEC3) begin : g_dec
      assign we = capture;
      assign be = '1;
      assign d  = AES_MSG_DEC[32*(11-i) +: 32];
    end else begin : g_bus
      assign we = bus_wr && (AVL_ADDR == IDX) && !(LOCKABLE && start_cur);
      assign be = AVL_BYTE_EN;
      assign d  = AVL_WRITEDATA;
    end

    be_reg32 u_reg (.clk(CLK), .rst(RESET), .we(we), .be(be), .d(d), .q(q));
    assign r[i] = q;
  end

  always_comb begin
    ctrl_wdata            = '0;
    ctrl_wdata[START_BIT] = AVL_WRITEDATA[START_BIT];
    status_word           = '0;
    status_word[DONE_BIT] = done_q;
  end

  // Only the START lane is ever enabled, so R14[31:1] stays zero.
  be_reg32 u_ctrl (
    .clk(CLK), .rst(RESET), .we(ctrl_wr), .be(4'b0001),
    .d(ctrl_wdata), .q(r[CTRL])
  );
  assign r[STATUS] = status_word;

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_next) begin
          state_d = ST_RUN;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (AES_DONE) begin
          capture = 1'b1;
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end else if (!start_next) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!start_next) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (AVL_CS && AVL_READ) rdata_d = r[AVL_ADDR];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef AES_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (bus_wr && (AVL_ADDR == STATUS)) irq_d = 1'b0;
    if (capture) irq_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign IRQ = irq_q;
`endif

  assign AVL_READDATA = rdata_q;
  assign AES_START    = start_cur;
  assign AES_KEY      = {r[KEY0], r[KEY1], r[KEY2], r[KEY3]};
  assign AES_MSG_ENC  = {r[MSG0], r[MSG1], r[MSG2], r[MSG3]};
  assign EXPORT_DATA  = {r[DEC0][31:16], r[DEC3][15:0]};

endmodule

// File: doc/avalon_aes_interface.md
AVALON_AES_INTERFACE -- requirements
Module: avalon_aes_interface

Interface
REQ-001 SHALL have no parameters; all sizes are fixed.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 AVL_CS  input  1  Avalon-MM chip select.
REQ-005 AVL_READ  input  1  read strobe, qualified by AVL_CS.
REQ-006 AVL_WRITE  input  1  write strobe, qualified by AVL_CS.
REQ-007 AVL_ADDR  input  4  word index of register R0..R15.
REQ-008 AVL_BYTE_EN  input  4  byte-lane write enables; bit n covers bits [8n+7:8n].
REQ-009 AVL_WRITEDATA  input  32  write data.
REQ-010 AVL_READDATA  output  32  read data, registered.
REQ-011 AES_START  output  1  start level to the downstream AES decrypt core.
REQ-012 AES_DONE  input  1  done level from the AES core.
REQ-013 AES_KEY  output  128  key; equals {R0,R1,R2,R3}.
REQ-014 AES_MSG_ENC  output  128  ciphertext; equals {R4,R5,R6,R7}.
REQ-015 AES_MSG_DEC  input  128  plaintext from the AES core.
REQ-016 EXPORT_DATA  output  32  equals {R8[31:16], R11[15:0]}, for the hex display.

Function
REQ-017 Register map:
- R0-R3: key, read/write.
- R4-R7: ciphertext, read/write.
- R8-R11: plaintext, read-only.
- R12-R13: scratch, read/write.
- R14: control; bit0 = START, bits [31:1] read as 0.
- R15: status; bit0 = DONE, read-only, bits [31:1] read as 0.
REQ-018 SHALL update, when AVL_CS&AVL_WRITE, only the byte lanes of R[AVL_ADDR] whose AVL_BYTE_EN bit is set, at the next clock edge.
REQ-019 SHALL ignore writes to R8-R11 and R15.
REQ-020 SHALL ignore writes to R0-R7 while R14[0]=1, so the AES inputs stay stable during a run.
REQ-021 SHALL, when AVL_CS&AVL_READ, load AVL_READDATA with R[AVL_ADDR] one cycle later (read latency 1); otherwise AVL_READDATA SHALL hold its last value.
REQ-022 SHALL drive AES_START = R14[0] combinationally.
REQ-023 Run state machine, states IDLE, RUN, HOLD:
- IDLE -> RUN when R14[0] goes 0->1; R15[0] SHALL clear on that edge.
- RUN -> HOLD on the first edge with AES_DONE=1; on that edge, capture AES_MSG_DEC into R8-R11 (R8 = bits [127:96]) and set R15[0].
- HOLD -> IDLE when R14[0] is written 0; R15[0] SHALL stay set.
REQ-024 SHALL give priority to the capture when AES_DONE is sampled in RUN in the same cycle as a bus write to R14; the R14 write SHALL still take effect.
REQ-025 SHALL ignore AES_DONE in IDLE and HOLD; no capture occurs.
REQ-026 SHALL allow START to be written 0 in RUN: FSM returns to IDLE, R15[0] stays 0, R8-R11 unchanged.

Reset
REQ-027 SHALL, on RESET, immediately clear R0-R15 and AVL_READDATA to 0, putting AES_START, AES_KEY, AES_MSG_ENC and EXPORT_DATA at 0 and the FSM in IDLE.
REQ-028 SHALL abandon an in-flight run when RESET is asserted mid-run; nothing is captured.

Configuration
REQ-029 Macro AES_IRQ_EN: when defined, SHALL add output IRQ (1 bit), set on the RUN->HOLD edge, cleared by any write to R15, reset 0.
REQ-030 Without AES_IRQ_EN, the IRQ port and its logic SHALL be absent, and writes to R15 SHALL remain no-ops.

Structure
REQ-031 Package aes_if_pkg SHALL hold the register index constants (KEY0..STATUS), the run-state enum, and the START/DONE bit positions.
REQ-032 SHALL instantiate sub-module be_reg32 (32-bit register with byte enables, asynchronous reset) for every writable word.

Verification
REQ-033 Byte enables: write 0xAABBCCDD to R12 with BYTE_EN=0101 over reset contents -> R12 reads 0x00BB00DD one cycle after the read.
REQ-034 Full run with a stub AES returning 0xECE298DC in every word after 10 cycles:
- write R0-R3 = 00010203,04050607,08090A0B,0C0D0E0F;
- write R4-R7 = DAEC3055,DF058E1C,39E814EA,76F6747E;
- write R14 = 1.
-> AES_KEY = 000102030405060708090A0B0C0D0E0F; R8-R11 = ECE298DC; R15 = 1; EXPORT_DATA = ECE298DC.
REQ-035 Lock: write R0 = FFFFFFFF while R14[0]=1 -> R0 unchanged; after R14 is written 0, the same write succeeds.
REQ-036 Simultaneous: AES_DONE rises in the cycle R14 is written 0 -> plaintext captured, R15 = 1, AES_START = 0 next cycle.
REQ-037 Reset mid-run: assert RESET 3 cycles after START -> all registers 0 immediately, no capture; a later AES_DONE pulse is ignored.
REQ-038 With AES_IRQ_EN defined: IRQ rises on the done capture, and a write of 0 to R15 clears it next cycle.
